// File: rtl/lms_conv_monitor.sv
// -----------------------------------------------------------------------------
// lms_conv_monitor
//
// Watches the error stream of an LMS adaptive filter and decides whether the
// filter has converged, is still tracking, or has diverged. A leaky average of
// |e| is compared against a lock threshold and a divergence limit, with run
// counters providing hysteresis for lock, loss of lock and divergence.
//
// Optional feature:
//   LMS_MON_PEAK_EN  when defined, builds the peak |e| register; when not
//                    defined Peak_err is tied to 0 and no peak register exists.
//
// Ports:
//   Clk         in   1   single clock, rising edge
//   Reset       in   1   synchronous active-high reset (wins over Clear)
//   Enable      in   1   sample-valid strobe for Error_in
//   Error_in    in  16   signed S5.11 LMS error sample
//   Threshold   in  16   unsigned lock threshold on the average |e|
//   Clear       in   1   synchronous soft restart (drops a coincident sample)
//   Err_avg     out 16   leaky average of |e|
//   Peak_err    out 16   peak |e| since restart (0 without LMS_MON_PEAK_EN)
//   Sample_cnt  out 16   accepted samples, saturating at 0xFFFF
//   State       out  3   IDLE=0, WARMUP=1, TRACK=2, CONVERGED=3, DIVERGED=4
//   Converged   out  1   high while State=CONVERGED
//   Diverged    out  1   high while State=DIVERGED
// -----------------------------------------------------------------------------
module lms_conv_monitor #(
  parameter int unsigned WARMUP_LEN = 64,
  parameter int unsigned AVG_SHIFT  = 4,
  parameter int unsigned HOLD_LEN   = 32,
  parameter int unsigned DIV_LEN    = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [15:0] Error_in,
  input  logic [15:0] Threshold,
  input  logic        Clear,
  output logic [15:0] Err_avg,
  output logic [15:0] Peak_err,
  output logic [15:0] Sample_cnt,
  output logic [2:0]  State,
  output logic        Converged,
  output logic        Diverged
);

  localparam int unsigned DW = 16;  // sample / average width
  localparam int unsigned AW = 18;  // signed working width for the average update
  localparam int unsigned CW = 16;  // counter width

  localparam logic [DW-1:0] MAG_MAX = 16'h7FFF;
  localparam logic [DW-1:0] NEG_MAX = 16'h8000;
  localparam logic [CW-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WARMUP    = 3'd1,
    ST_TRACK     = 3'd2,
    ST_CONVERGED = 3'd3,
    ST_DIVERGED  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_next;

  logic [DW-1:0]   avg_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   run_q;     // below-threshold run in TRACK, at-or-above run in CONVERGED
  logic [CW-1:0]   above_q;   // above-limit run in TRACK and CONVERGED
  logic            conv_q;
  logic            div_q;

  logic [DW-1:0]   avg_d;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   run_d;
  logic [CW-1:0]   above_d;
  logic            conv_d;
  logic            div_d;

  logic            accept;
  logic [DW-1:0]   mag;
  logic signed [AW-1:0] avg_diff;
  logic signed [AW-1:0] avg_step;
  logic signed [AW-1:0] avg_sum;
  logic [DW-1:0]   avg_new;
  logic [DW-1:0]   div_limit;
  logic            below;
  logic            above;
  logic            run_cond;
  logic [CW-1:0]   cnt_new;
  logic [CW-1:0]   run_new;
  logic [CW-1:0]   above_new;
  logic            lock_hit;
  logic            loss_hit;
  logic            div_hit;

  // A sample counts only when strobed and not cancelled by a soft restart.
  assign accept = Enable && !Clear;

  // |e| with the single unrepresentable magnitude (-16.0) clipped to +max.
  always_comb begin
    mag = Error_in;
    if (Error_in == NEG_MAX) begin
      mag = MAG_MAX;
    end else if (Error_in[DW-1]) begin
      mag = DW'(~Error_in + 16'd1);
    end
  end

  // Leaky average: avg + ((|e| - avg) >>> AVG_SHIFT), clamped to 0..0x7FFF.
  always_comb begin
    avg_diff = $signed({2'b00, mag}) - $signed({2'b00, avg_q});
    avg_step = avg_diff >>> AVG_SHIFT;
    avg_sum  = $signed({2'b00, avg_q}) + avg_step;
    if (avg_sum < 18'sd0) begin
      avg_new = '0;
    end else if (avg_sum > 18'sd32767) begin
      avg_new = MAG_MAX;
    end else begin
      avg_new = avg_sum[DW-1:0];
    end
  end

  // Divergence limit is 4x the threshold, saturating at 0xFFFF.
  assign div_limit = (Threshold[DW-1:DW-2] != 2'b00) ? 16'hFFFF
                                                     : {Threshold[DW-3:0], 2'b00};

  assign below = (avg_new < Threshold);
  assign above = (avg_new > div_limit);

  // Run counter meaning depends on the state: lock run in TRACK, loss run in CONVERGED.
  assign run_cond  = (state_q == ST_CONVERGED) ? !below : below;

  assign cnt_new   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
  assign run_new   = run_cond ? run_q + 16'd1 : '0;
  assign above_new = above ? above_q + 16'd1 : '0;

  assign lock_hit  = (state_q == ST_TRACK)     && (run_new >= CW'(HOLD_LEN));
  assign loss_hit  = (state_q == ST_CONVERGED) && (run_new >= CW'(HOLD_LEN));
  assign div_hit   = (above_new >= CW'(DIV_LEN));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; divergence has priority over lock and loss of lock.
  always_comb begin
    state_next = state_q;
    if (Clear) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          state_next = ST_WARMUP;
        end
        ST_WARMUP: begin
          if (cnt_new >= CW'(WARMUP_LEN)) begin
            state_next = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (div_hit) begin
            state_next = ST_DIVERGED;
          end else if (lock_hit) begin
            state_next = ST_CONVERGED;
          end
        end
        ST_CONVERGED: begin
          if (div_hit) begin
            state_next = ST_DIVERGED;
          end else if (loss_hit) begin
            state_next = ST_TRACK;
          end
        end
        ST_DIVERGED: begin
          state_next = ST_DIVERGED;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    avg_d   = avg_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    above_d = above_q;
    if (Clear) begin
      avg_d   = '0;
      cnt_d   = '0;
      run_d   = '0;
      above_d = '0;
    end else if (accept) begin
      avg_d = avg_new;
      cnt_d = cnt_new;
      if ((state_q == ST_TRACK) || (state_q == ST_CONVERGED)) begin
        run_d   = run_new;
        above_d = above_new;
      end else begin
        run_d   = '0;
        above_d = '0;
      end
      // Run counters restart from zero whenever a new state is entered.
      if (state_next != state_q) begin
        run_d   = '0;
        above_d = '0;
      end
    end
    conv_d = (state_next == ST_CONVERGED);
    div_d  = (state_next == ST_DIVERGED);
  end

  // Datapath and status flag registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      avg_q   <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      above_q <= '0;
      conv_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      avg_q   <= avg_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      above_q <= above_d;
      conv_q  <= conv_d;
      div_q   <= div_d;
    end
  end

`ifdef LMS_MON_PEAK_EN
  logic [DW-1:0] peak_q;

  // Peak |e| since the last Reset or Clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      peak_q <= '0;
    end else if (Clear) begin
      peak_q <= '0;
    end else if (accept && (mag > peak_q)) begin
      peak_q <= mag;
    end
  end

  assign Peak_err = peak_q;
`else
  assign Peak_err = '0;
`endif

  assign Err_avg    = avg_q;
  assign Sample_cnt = cnt_q;
  assign State      = state_q;
  assign Converged  = conv_q;
  assign Diverged   = div_q;

endmodule

// File: tb/tb_lms_conv_monitor.sv
`timescale 1ns/1ps
module tb_lms_conv_monitor;

  localparam int WARMUP = 64;
  localparam int SHIFT  = 4;
  localparam int HOLD   = 32;
  localparam int DIVL   = 32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [15:0] Error_in;
  logic [15:0] Threshold;
  logic        Clear;
  logic [15:0] Err_avg;
  logic [15:0] Peak_err;
  logic [15:0] Sample_cnt;
  logic [2:0]  State;
  logic        Converged;
  logic        Diverged;

  int compared   = 0;
  int mismatched = 0;
  string phase   = "init";

  // Reference model state: plain integers driven by the rules of the monitor.
  int m_avg, m_peak, m_cnt, m_state;
  int m_lock_run, m_loss_run, m_div_run;

  lms_conv_monitor dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Enable     (Enable),
    .Error_in   (Error_in),
    .Threshold  (Threshold),
    .Clear      (Clear),
    .Err_avg    (Err_avg),
    .Peak_err   (Peak_err),
    .Sample_cnt (Sample_cnt),
    .State      (State),
    .Converged  (Converged),
    .Diverged   (Diverged)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_restart();
    m_avg = 0; m_peak = 0; m_cnt = 0; m_state = 0;
    m_lock_run = 0; m_loss_run = 0; m_div_run = 0;
  endtask

  task automatic model(input bit rst, input bit clr, input bit en,
                       input logic [15:0] e, input logic [15:0] thr);
    int s, mag, a, lim, th;
    if (rst || clr) begin
      model_restart();
    end else if (en) begin
      s   = int'($signed(e));
      mag = (s < 0) ? -s : s;
      if (mag > 32767) mag = 32767;
      a = m_avg + ((mag - m_avg) >>> SHIFT);
      if (a < 0) a = 0;
      if (a > 32767) a = 32767;
      m_avg = a;
      if (mag > m_peak) m_peak = mag;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      th  = int'(thr);
      lim = th * 4;
      if (lim > 65535) lim = 65535;
      case (m_state)
        0: m_state = 1;
        1: if (m_cnt >= WARMUP) begin
             m_state = 2; m_lock_run = 0; m_div_run = 0;
           end
        2: begin
             m_lock_run = (a < th) ? m_lock_run + 1 : 0;
             m_div_run  = (a > lim) ? m_div_run + 1 : 0;
             if (m_div_run >= DIVL) m_state = 4;
             else if (m_lock_run >= HOLD) begin
               m_state = 3; m_loss_run = 0; m_div_run = 0;
             end
           end
        3: begin
             m_loss_run = (a >= th) ? m_loss_run + 1 : 0;
             m_div_run  = (a > lim) ? m_div_run + 1 : 0;
             if (m_div_run >= DIVL) m_state = 4;
             else if (m_loss_run >= HOLD) begin
               m_state = 2; m_lock_run = 0; m_div_run = 0;
             end
           end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_peak;
`ifdef LMS_MON_PEAK_EN
    exp_peak = 16'(m_peak);
`else
    exp_peak = 16'h0000;
`endif
    chk({phase, "/avg"},   Err_avg,    16'(m_avg));
    chk({phase, "/peak"},  Peak_err,   exp_peak);
    chk({phase, "/cnt"},   Sample_cnt, 16'(m_cnt));
    chk({phase, "/state"}, {13'd0, State},     16'(m_state));
    chk({phase, "/conv"},  {15'd0, Converged}, 16'(m_state == 3));
    chk({phase, "/div"},   {15'd0, Diverged},  16'(m_state == 4));
  endtask

  // One clock: drive, model the edge, sample 1 ns after it.
  task automatic cyc(input bit rst, input bit clr, input bit en,
                     input logic [15:0] e, input logic [15:0] thr);
    Reset = rst; Clear = clr; Enable = en; Error_in = e; Threshold = thr;
    @(posedge Clk);
    model(rst, clr, en, e, thr);
    #1;
    check_all();
  endtask

  function automatic logic [15:0] rand_err(input int lo, input int hi);
    logic [15:0] m;
    m = 16'($urandom_range(hi, lo));
    return ($urandom_range(1, 0) == 1) ? 16'(-m) : m;
  endfunction

  initial begin
    model_restart();
    Reset = 1'b1; Clear = 1'b0; Enable = 1'b0; Error_in = '0; Threshold = '0;

    // Reset state
    phase = "reset";
    cyc(1, 0, 1, 16'h1234, 16'h0010);
    cyc(1, 0, 0, 16'h0000, 16'h0010);
    chk("reset_state", {13'd0, State}, 16'd0);
    chk("reset_avg", Err_avg, 16'h0000);
    chk("reset_cnt", Sample_cnt, 16'h0000);

    // Zero error locks after warmup + hold
    phase = "lock0";
    for (int i = 1; i <= 96; i++) begin
      cyc(0, 0, 1, 16'h0000, 16'h0010);
      if (i == 63) chk("warm_63", {13'd0, State}, 16'd1);
      if (i == 64) chk("track_64", {13'd0, State}, 16'd2);
      if (i == 95) chk("conv_95", {15'd0, Converged}, 16'd0);
    end
    chk("conv_96", {15'd0, Converged}, 16'd1);
    chk("conv_avg", Err_avg, 16'h0000);

    // Loss of lock: average sits between threshold and limit
    phase = "loss";
    for (int i = 0; i < 80; i++) cyc(0, 0, 1, rand_err(16'h100, 16'h200), 16'h0100);
    chk("loss_track", {13'd0, State}, 16'd2);

    // Re-lock with small errors
    phase = "relock";
    for (int i = 0; i < 120; i++) cyc(0, 0, 1, rand_err(0, 16'h20), 16'h0100);
    chk("relock_conv", {13'd0, State}, 16'd3);

    phase = "loss2";
    for (int i = 0; i < 80; i++) cyc(0, 0, 1, rand_err(16'h100, 16'h200), 16'h0100);
    chk("loss2_track", {13'd0, State}, 16'd2);

    // Clear with Enable in TRACK drops the sample
    phase = "clear_en";
    cyc(0, 1, 1, 16'h1234, 16'h0100);
    chk("clr_state", {13'd0, State}, 16'd0);
    chk("clr_avg", Err_avg, 16'h0000);
    chk("clr_cnt", Sample_cnt, 16'h0000);

    // Divergence and its stickiness
    phase = "diverge";
    for (int i = 1; i <= 96; i++) begin
      cyc(0, 0, 1, 16'h0800, 16'h0010);
      if (i == 95) chk("div_95", {15'd0, Diverged}, 16'd0);
    end
    chk("div_96", {15'd0, Diverged}, 16'd1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 16'h0000, 16'h0010);
    chk("div_sticky", {15'd0, Diverged}, 16'd1);
    cyc(0, 1, 0, 16'h0000, 16'h0010);
    chk("div_clear", {15'd0, Diverged}, 16'd0);

    // Most negative sample
    phase = "negmax";
    cyc(0, 0, 1, 16'h8000, 16'h0010);
    chk("negmax_avg", Err_avg, 16'h07FF);
`ifdef LMS_MON_PEAK_EN
    chk("negmax_peak", Peak_err, 16'h7FFF);
`else
    chk("negmax_peak", Peak_err, 16'h0000);
`endif

    // Enable toggling every other cycle
    phase = "toggle";
    cyc(0, 1, 0, 16'h0000, 16'h0010);
    for (int i = 0; i < 192; i++) begin
      cyc(0, 0, (i % 2) == 0, 16'h0000, 16'h0010);
      if (i == 188) chk("tog_conv_95", {15'd0, Converged}, 16'd0);
      if (i == 190) chk("tog_conv_96", {15'd0, Converged}, 16'd1);
    end
    chk("tog_cnt", Sample_cnt, 16'd96);

    // Reset in CONVERGED, then re-lock on the same timeline
    phase = "rst_conv";
    cyc(1, 0, 1, 16'h7000, 16'h0010);
    chk("rstc_state", {13'd0, State}, 16'd0);
    chk("rstc_avg", Err_avg, 16'h0000);
    chk("rstc_peak", Peak_err, 16'h0000);
    chk("rstc_cnt", Sample_cnt, 16'h0000);
    chk("rstc_conv", {15'd0, Converged}, 16'd0);
    for (int i = 1; i <= 96; i++) begin
      cyc(0, 0, 1, 16'h0000, 16'h0010);
      if (i == 64) chk("rstc_track", {13'd0, State}, 16'd2);
      if (i == 95) chk("rstc_conv_95", {15'd0, Converged}, 16'd0);
    end
    chk("rstc_conv_96", {15'd0, Converged}, 16'd1);

    // Randomized regimes against the model
    phase = "random";
    for (int blk = 0; blk < 20; blk++) begin
      int regime;
      logic [15:0] thr;
      regime = int'($urandom_range(3, 0));
      case ($urandom_range(5, 0))
        0: thr = 16'h0010;
        1: thr = 16'h0100;
        2: thr = 16'h3FFF;
        3: thr = 16'h4000;
        4: thr = 16'hFFFF;
        default: thr = 16'($urandom);
      endcase
      for (int i = 0; i < 150; i++) begin
        logic [15:0] e;
        bit rst, clr, en;
        case (regime)
          0: e = rand_err(0, 16'h20);
          1: e = rand_err(16'h100, 16'h800);
          2: e = ($urandom_range(7, 0) == 0) ? 16'h8000 : 16'($urandom);
          default: e = rand_err(0, 16'h7FFF);
        endcase
        rst = ($urandom_range(599, 0) == 0);
        clr = ($urandom_range(299, 0) == 0);
        en  = ($urandom_range(9, 0) < 8);
        if ((i % 16) == 0) thr = thr ^ 16'($urandom_range(3, 0));
        cyc(rst, clr, en, e, thr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lms_conv_monitor.md
LMS_CONV_MONITOR -- requirements
Module: lms_conv_monitor

Interface
REQ-001 Parameter WARMUP_LEN, default 64, enabled samples ignored before tracking starts.
REQ-002 Parameter AVG_SHIFT, default 4, leaky-average coefficient 2^-AVG_SHIFT.
REQ-003 Parameter HOLD_LEN, default 32, consecutive samples needed for lock or loss of lock.
REQ-004 Parameter DIV_LEN, default 32, consecutive samples above the divergence limit needed to declare divergence.
REQ-005 Clk  in  1  single clock; all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Enable  in  1  sample-valid strobe for Error_in, one sample per high cycle.
REQ-008 Error_in  in  16  signed S5.11 LMS error sample, e(n) = d(n) - y(n).
REQ-009 Threshold  in  16  unsigned lock threshold on the average |e|.
REQ-010 Clear  in  1  synchronous soft restart.
REQ-011 Err_avg  out  16  unsigned leaky average of |e|.
REQ-012 Peak_err  out  16  unsigned peak |e| since restart.
REQ-013 Sample_cnt  out  16  count of accepted samples, saturating.
REQ-014 State  out  3  IDLE=0, WARMUP=1, TRACK=2, CONVERGED=3, DIVERGED=4.
REQ-015 Converged  out  1  high while State=CONVERGED.
REQ-016 Diverged  out  1  high while State=DIVERGED.

Function
REQ-017 A sample is accepted on any cycle with Enable=1 and Clear=0; with Enable=0, all registers hold.
REQ-018 |e| is the absolute value of Error_in; 0x8000 saturates to 0x7FFF.
REQ-019 The average update is avg_new = avg + ((|e| - avg) >>> AVG_SHIFT), computed in an 18-bit signed arithmetic shift and clamped to 0..0x7FFF.
REQ-020 Err_avg, Peak_err, Sample_cnt and State are registered and reflect an accepted sample one cycle after it.
REQ-021 All comparisons use avg_new of the current sample; Threshold is sampled on each accepted sample.
REQ-022 The divergence limit is Threshold<<2, saturated to 0xFFFF.
REQ-023 Sample_cnt increments per accepted sample and saturates at 0xFFFF.
REQ-024 IDLE goes to WARMUP on the first accepted sample, and that sample is counted.
REQ-025 WARMUP goes to TRACK on the accepted sample where Sample_cnt reaches WARMUP_LEN; the average updates during warmup but is not compared.
REQ-026 In TRACK, below_cnt increments when avg_new < Threshold and clears otherwise.
REQ-027 In TRACK, above_cnt increments when avg_new > the limit and clears otherwise.
REQ-028 In TRACK, both run counters start at 0 on entry.
REQ-029 TRACK goes to CONVERGED when below_cnt reaches HOLD_LEN, and to DIVERGED when above_cnt reaches DIV_LEN; if both occur on the same sample, DIVERGED wins.
REQ-030 CONVERGED goes back to TRACK after HOLD_LEN consecutive samples with avg_new >= Threshold, clearing both run counters.
REQ-031 CONVERGED goes to DIVERGED under the same above_cnt rule as TRACK.
REQ-032 DIVERGED is sticky and is left only by Reset or Clear.
REQ-033 Clear forces IDLE and zeroes the average, peak, Sample_cnt and run counters.
REQ-034 Clear with Enable in the same cycle drops the sample.
REQ-035 Reset has priority over Clear.

Reset
REQ-036 On a Reset cycle, on the next edge, all outputs are 0, State is IDLE, and all internal counters and accumulators are 0.
REQ-037 Reset asserted mid-operation in any state gives the same result as REQ-036, and the sample present during Reset is discarded.

Configuration
REQ-038 The macro LMS_MON_PEAK_EN, when defined, compiles in the peak register: Peak_err = max |e| over accepted samples since restart.
REQ-039 Without LMS_MON_PEAK_EN, Peak_err is constant 0 and no peak register is built; all other behaviour is identical.

Verification
REQ-040 Reset; Error_in=0, Threshold=0x0010, Enable=1 each cycle -> State=2 after sample 64, Converged=1 the cycle after sample 96, Err_avg=0.
REQ-041 Error_in=0x0800, Threshold=0x0010 -> Diverged=1 the cycle after sample 96; it stays 1 after Error_in=0 until Clear.
REQ-042 Single sample Error_in=0x8000 -> Peak_err=0x7FFF with LMS_MON_PEAK_EN, Peak_err=0 without it; Err_avg=0x07FF after one sample from 0.
REQ-043 Enable toggling every other cycle with Error_in=0 -> Sample_cnt advances only on high cycles; Converged=1 after 96 accepted samples (192 cycles).
REQ-044 Clear=1 and Enable=1 together in TRACK -> next cycle State=0, Err_avg=0, Sample_cnt=0, sample ignored.
REQ-045 Reset pulsed in CONVERGED -> next cycle all outputs 0; re-lock follows the REQ-040 timeline.
